// File: rtl/byte_deserializer.sv
// byte_deserializer
//   Packs a stream of 8-bit UART bytes into N-bit operand words for the
//   modular-exponentiation core.
//   The byte order is selectable. A word may be ended early with in_last,
//   which zero-pads the unused lanes. A partly built word can be discarded
//   with flush. Both sides use ready/valid handshakes.
//
// Parameters
//   N          output word width (multiple of 8, >= 16)
//   MSB_FIRST  1: first byte lands in [N-1:N-8]; 0: first byte lands in [7:0]
//   CW         byte counter width, 2^CW > N/8
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        in_byte/in_last are valid this cycle
//   in_byte         received byte
//   in_last         this byte ends the current word
//   in_ready        byte accepted when in_valid && in_ready
//   flush           discard the partial word (synchronous)
//   out_word        assembled word
//   out_nbytes      valid bytes in out_word (1..N/8)
//   out_valid       out_word/out_nbytes valid
//   out_ready       consumer takes the word when out_valid && out_ready
//   partial_count   bytes currently held in the assembly register
module byte_deserializer #(
  parameter int N         = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          flush,
  output logic [N-1:0]  out_word,
  output logic [CW-1:0] out_nbytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] partial_count
);

  localparam int            BYTES    = N / 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);

  logic [N-1:0]  asm_reg;
  logic [CW-1:0] cnt;
  logic [N-1:0]  word_next;
  logic          slot_free;
  logic          completing;
  logic          accept;

  assign slot_free     = !out_valid || out_ready;
  assign completing    = in_last || (cnt == LAST_IDX);

  // A non-completing byte never touches the output register. It may
  // therefore be accepted while a finished word is still waiting for the
  // consumer.
  assign in_ready      = !flush && (slot_free || ((cnt < LAST_IDX) && !in_last));
  assign accept        = in_valid && in_ready;
  assign partial_count = cnt;

  // The assembly register with the incoming byte placed in lane cnt.
  // Every lane above cnt is forced to zero. For a non-completing byte this
  // is the next value of asm_reg. For a completing byte it is the padded
  // output word.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (MSB_FIRST) begin
        if (CW'(k) == cnt)
          word_next[N-8-8*k +: 8] = in_byte;
        else if (CW'(k) < cnt)
          word_next[N-8-8*k +: 8] = asm_reg[N-8-8*k +: 8];
      end else begin
        if (CW'(k) == cnt)
          word_next[8*k +: 8] = in_byte;
        else if (CW'(k) < cnt)
          word_next[8*k +: 8] = asm_reg[8*k +: 8];
      end
    end
  end

  // Assembly register and byte counter.
  // flush also blocks in_ready, so it can never collide with an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg <= '0;
      cnt     <= '0;
    end else if (flush) begin
      asm_reg <= '0;
      cnt     <= '0;
    end else if (accept) begin
      if (completing) begin
        asm_reg <= '0;
        cnt     <= '0;
      end else begin
        asm_reg <= word_next;
        cnt     <= cnt + CW'(1);
      end
    end
  end

  // Output register.
  // A completing accept is only possible when the slot is free. Loading a
  // new word therefore also covers the case where the old word is handed
  // off in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word   <= '0;
      out_nbytes <= '0;
      out_valid  <= 1'b0;
    end else if (accept && completing) begin
      out_word   <= word_next;
      out_nbytes <= cnt + CW'(1);
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
